// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG blocks: FSM state encoding, default
// parameter values and a counter-width helper.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  localparam int N_RO_DEF       = 4;
  localparam int WORD_W_DEF     = 32;
  localparam int SAMPLE_DIV_DEF = 8;
  localparam int WARMUP_CYC_DEF = 256;
  localparam int REP_LIMIT_DEF  = 32;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vn_corrector.sv
// Von Neumann debiaser: pairs successive sampled bits (a, b); 10 -> 1,
// 01 -> 0, equal pairs emit nothing. bit_valid is combinational on the tick.
module vn_corrector (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic raw,
  input  logic sample_tick,
  output logic bit_valid,
  output logic vn_bit
);

  logic have_a;
  logic first;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      have_a <= 1'b0;
      first  <= 1'b0;
    end else if (sample_tick) begin
      have_a <= !have_a;
      if (!have_a) first <= raw;
    end
  end

  assign bit_valid = sample_tick && have_a && (first != raw);
  assign vn_bit    = first;

endmodule

// File: rtl/trng_sampler.sv
// Ring-oscillator entropy back end: enables and synchronizes the oscillators,
// decimates and debiases the XORed stream, packs words and health-tests it.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int N_RO       = N_RO_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int WARMUP_CYC = WARMUP_CYC_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_RO-1:0]   ro_out,
  output logic [N_RO-1:0]   ro_ctrl,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              overrun,
  output logic              health_fail
);

  localparam int DIV_W  = cnt_w(SAMPLE_DIV);
  localparam int WARM_W = cnt_w(WARMUP_CYC);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam int BIT_W  = cnt_w(WORD_W);

  state_t state, state_nxt;

  logic [N_RO-1:0]   sync1, sync2;
  logic [DIV_W-1:0]  div_cnt;
  logic [WARM_W-1:0] warm_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              last_raw;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shift, word_nxt;
  logic              raw, run_active, sample_tick, trip, word_done;
  logic              bit_valid, vn_bit;

  assign raw         = ^sync2;
  assign run_active  = (state == ST_RUN) && enable;
  assign sample_tick = run_active && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign trip        = sample_tick && (raw == last_raw) &&
                       (rep_cnt == REP_W'(REP_LIMIT - 1));
  assign word_nxt    = {shift[WORD_W-2:0], vn_bit};
  // A trip discards the word in progress, including a bit arriving that tick.
  assign word_done   = bit_valid && !trip && (bit_cnt == BIT_W'(WORD_W - 1));

  vn_corrector u_vn (
    .clk         (clk),
    .rst         (rst),
    .restart     (!run_active),
    .raw         (raw),
    .sample_tick (sample_tick),
    .bit_valid   (bit_valid),
    .vn_bit      (vn_bit)
  );

  // NOTE: every always_comb output gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ro_ctrl   = '0;
    unique case (state)
      ST_IDLE:   if (enable) state_nxt = ST_WARMUP;
      ST_WARMUP: begin
        ro_ctrl = '1;
        if (!enable) state_nxt = ST_IDLE;
        else if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ro_ctrl = '1;
        if (!enable) state_nxt = ST_IDLE;
        else if (trip) state_nxt = ST_FAIL;
      end
      ST_FAIL:   if (!enable) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sync1    <= '0;
      sync2    <= '0;
      warm_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      sync1    <= ro_out;
      sync2    <= sync1;
      warm_cnt <= (state == ST_WARMUP) ? warm_cnt + 1'b1 : '0;
      div_cnt  <= (!run_active || sample_tick) ? '0 : div_cnt + 1'b1;
    end
  end

  // Repetition health test on the raw sample stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt     <= '0;
      last_raw    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (!run_active) begin
        rep_cnt <= '0;
      end else if (sample_tick) begin
        last_raw <= raw;
        if (rep_cnt != '0 && raw == last_raw) rep_cnt <= rep_cnt + 1'b1;
        else rep_cnt <= REP_W'(1);
      end
      if (trip) health_fail <= 1'b1;
    end
  end

  // Packer and single-entry output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift     <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (!run_active || trip) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (bit_valid) begin
        shift   <= word_nxt;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end

      if (word_done) begin
        if (!rnd_valid || rnd_ready) begin
          rnd_data  <= word_nxt;
          rnd_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rnd_valid && rnd_ready) begin
        rnd_valid <= 1'b0;
      end

      if (state == ST_IDLE && enable) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares each newly presented word.
module tb_trng_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] ro_out;
  logic [3:0] ro_ctrl;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       overrun;
  logic       health_fail;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  logic [1:0] pairs [10] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00,
                             2'b10, 2'b01, 2'b01, 2'b10, 2'b01};

  trng_sampler #(
    .N_RO(4), .WORD_W(8), .SAMPLE_DIV(4), .WARMUP_CYC(16), .REP_LIMIT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ro_out      (ro_out),
    .ro_ctrl     (ro_ctrl),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .overrun     (overrun),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // A new word is on the port when valid rises or follows a transfer.
  always @(negedge clk) begin
    if (rst === 1'b0 && rnd_valid === 1'b1 && (!prev_valid || prev_ready)) begin
      check("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("word_data", 32'(rnd_data), 32'(exp_q.pop_front()));
    end
    prev_valid = (rnd_valid === 1'b1);
    prev_ready = (rnd_ready === 1'b1);
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after edge T-3; the value is what the tick at edge T samples.
  task automatic send(input logic b);
    ro_out = {3'b000, b};
    wait_edges(4);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin send(1'b1); send(1'b0); end
    else begin send(1'b0); send(1'b1); end
  endtask

  task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  // Pairs 00,11,00,... keep the raw stream moving without emitting bits.
  task automatic filler(input int npairs);
    for (int i = 0; i < npairs; i++) begin
      send(1'(i % 2));
      send(1'(i % 2));
    end
  endtask

  // Leaves the caller just after edge E0+17 so the first send hits tick E0+20.
  task automatic start_run();
    enable = 1'b1;
    check("ctrl_low_before_enable_sampled", 32'(ro_ctrl), 32'h0);
    wait_edges(1);
    check("ctrl_high_after_enable", 32'(ro_ctrl), 32'hF);
    wait_edges(17);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; rnd_ready = 1'b0; ro_out = 4'h0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {ro_ctrl, rnd_valid, overrun, health_fail, rnd_data}, 32'h0);
    end
    rst = 1'b0;
    start_run();

    // Correction and packing: expected 1,0,1,1,0,0,1,0.
    exp_q.push_back(8'b1011_0010);
    for (int i = 0; i < 10; i++) begin
      send(pairs[i][1]);
      if (i == 9) check("valid_low_before_last_tick", 32'(rnd_valid), 32'd0);
      send(pairs[i][0]);
    end
    check("valid_after_last_tick", {rnd_valid, rnd_data}, 32'h1B2);

    filler(13);
    check("data_stable_during_stall", {rnd_valid, rnd_data}, 32'h1B2);

    // Overrun: two more words with the consumer stalled.
    send_bits(8'h5A, 7, 1);
    check("no_overrun_before_completion", 32'(overrun), 32'd0);
    send_bit(1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    check("held_word_after_drop", {rnd_valid, rnd_data}, 32'h1B2);
    send_bits(8'hC3, 7, 0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("held_word_after_second_drop", 32'(rnd_data), 32'hB2);

    enable = 1'b0;
    wait_edges(2);
    check("ctrl_low_when_disabled", 32'(ro_ctrl), 32'h0);
    check("held_word_survives_disable", {rnd_valid, rnd_data}, 32'h1B2);
    check("overrun_held_in_idle", 32'(overrun), 32'd1);
    start_run();
    check("overrun_cleared_on_enable", 32'(overrun), 32'd0);

    // Back-to-back: ready asserted exactly on the completion cycle.
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 7, 1);
    send(1'b0);
    ro_out = 4'b0001;
    wait_edges(2);
    rnd_ready = 1'b1;
    wait_edges(1);
    rnd_ready = 1'b0;
    check("b2b_valid_stays_high", {rnd_valid, rnd_data}, 32'h13C);
    check("b2b_no_overrun", 32'(overrun), 32'd0);
    wait_edges(1);

    rnd_ready = 1'b1;
    filler(1);
    rnd_ready = 1'b0;
    check("valid_drops_after_transfer", 32'(rnd_valid), 32'd0);

    // Disable mid-word: five 1-bits must not leak into the next word.
    send_bits(8'hFF, 7, 3);
    enable = 1'b0;
    wait_edges(2);
    check("ctrl_low_mid_word_disable", 32'(ro_ctrl), 32'h0);
    start_run();
    exp_q.push_back(8'h81);
    send_bits(8'h81, 7, 0);
    check("fresh_word_after_reenable", {rnd_valid, rnd_data}, 32'h181);

    // Health test: constant raw=1 after a 0 sample trips on the 8th tick.
    ro_out = 4'b0111;
    wait_edges(28);
    check("no_health_fail_at_7th_tick", 32'(health_fail), 32'd0);
    check("ctrl_high_before_trip", 32'(ro_ctrl), 32'hF);
    wait_edges(3);
    check("health_fail_at_8th_tick", 32'(health_fail), 32'd1);
    check("ctrl_low_in_fail", 32'(ro_ctrl), 32'h0);
    check("held_word_survives_fail", {rnd_valid, rnd_data}, 32'h181);

    enable = 1'b0;
    wait_edges(2);
    enable = 1'b1;
    wait_edges(1);
    check("ctrl_high_after_fail_reenable", 32'(ro_ctrl), 32'hF);
    check("health_fail_sticky", 32'(health_fail), 32'd1);

    // Reset mid-operation clears everything, including the held word.
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    enable = 1'b0;
    check("outputs_after_midrun_reset",
          {ro_ctrl, rnd_valid, overrun, health_fail, rnd_data}, 32'h0);
    wait_edges(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
